// File: rtl/neuron_layer_sequencer_pkg.sv
// Shared types and sizing helpers for the neuron layer sequencer.
package neuron_layer_sequencer_pkg;

  // Sequencer control states.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitRdy,
    StFire,
    StWaitRes,
    StNext,
    StFin
  } state_e;

  // Table size: each neuron owns num_inputs weights followed by one bias.
  function automatic int unsigned table_entries(input int unsigned num_neurons,
                                                input int unsigned num_inputs);
    return num_neurons * (num_inputs + 1);
  endfunction

endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// Handshake/data bundle between the sequencer and the shared neuron datapath.
interface neuron_layer_sequencer_if #(
  parameter int unsigned NumInputs = 2,
  parameter int unsigned Width     = 8
);

  logic [NumInputs*Width-1:0] weights;
  logic [Width-1:0]           bias;
  logic [Width-1:0]           value_in;
  logic                       valid_in;
  logic                       ready;
  logic [Width-1:0]           value_out;
  logic                       valid_out;
  logic                       overflow;

  // Sequencer side.
  modport master (
    output weights, bias, value_in, valid_in,
    input  ready, value_out, valid_out, overflow
  );

  // Neuron datapath side.
  modport slave (
    input  weights, bias, value_in, valid_in,
    output ready, value_out, valid_out, overflow
  );

endinterface

// File: rtl/neuron_param_table.sv
// Per-neuron weight/bias register file: one write port with range and lock
// checks, and a parallel read of all parameters for the selected neuron.
module neuron_param_table
  import neuron_layer_sequencer_pkg::*;
#(
  parameter int unsigned NumNeurons = 4,
  parameter int unsigned NumInputs  = 2,
  parameter int unsigned Width      = 8,
  localparam int unsigned Entries   = table_entries(NumNeurons, NumInputs),
  localparam int unsigned AddrW     = $clog2(Entries),
  localparam int unsigned IdxW      = $clog2(NumNeurons)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic                       locked,
  input  logic [AddrW-1:0]           addr,
  input  logic [Width-1:0]           wdata,
  input  logic [IdxW-1:0]            sel,
  output logic [NumInputs*Width-1:0] rd_weights,
  output logic [Width-1:0]           rd_bias,
  output logic                       wr_err
);

  localparam logic [AddrW:0] EntriesW = (AddrW + 1)'(Entries);

  logic [Width-1:0] mem_q [Entries];
  logic             wr_err_q;
  logic             in_range;
  logic             accept;
  logic [AddrW-1:0] rd_idx;

  assign in_range = {1'b0, addr} < EntriesW;
  // Writes are refused while a run is active so the run sees one table.
  assign accept   = we && !locked && in_range;
  assign wr_err   = wr_err_q;

  // Table storage and dropped-write pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        mem_q[i] <= '0;
      end
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= we && !accept;
      if (accept) begin
        mem_q[addr] <= wdata;
      end
    end
  end

  // Parallel read of the selected neuron's weights and bias.
  always_comb begin
    rd_weights = '0;
    rd_idx     = '0;
    for (int unsigned k = 0; k < NumInputs; k++) begin
      rd_idx = AddrW'(32'(sel) * (NumInputs + 1) + k);
      rd_weights[k*Width +: Width] = mem_q[rd_idx];
    end
    rd_idx  = AddrW'(32'(sel) * (NumInputs + 1) + NumInputs);
    rd_bias = mem_q[rd_idx];
  end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes one neuron datapath across NumNeurons logical neurons:
// loads each neuron's parameters, fires the datapath, collects the result.
module neuron_layer_sequencer
  import neuron_layer_sequencer_pkg::*;
#(
  parameter int unsigned NumNeurons    = 4,
  parameter int unsigned NumInputs     = 2,
  parameter int unsigned Width         = 8,
  parameter int unsigned TimeoutCycles = 64,
  localparam int unsigned Entries      = table_entries(NumNeurons, NumInputs),
  localparam int unsigned AddrW        = $clog2(Entries)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_we,
  input  logic [AddrW-1:0]            cfg_addr,
  input  logic [Width-1:0]            cfg_wdata,
  output logic                        cfg_err,
  input  logic                        start,
  input  logic [Width-1:0]            value_in,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [NumNeurons*Width-1:0] results,
  output logic [NumNeurons-1:0]       ovf_flags,
  neuron_layer_sequencer_if.master    nrn
);

  localparam int unsigned IdxW = $clog2(NumNeurons);
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [TmoW-1:0]            tmo_q, tmo_d;
  logic [Width-1:0]           value_q, value_d;
  logic [NumInputs*Width-1:0] weights_q, weights_d;
  logic [Width-1:0]           bias_q, bias_d;
  logic [NumNeurons*Width-1:0] results_q, results_d;
  logic [NumNeurons-1:0]      ovf_q, ovf_d;
  logic                       error_q, error_d;

  logic [NumInputs*Width-1:0] tbl_weights;
  logic [Width-1:0]           tbl_bias;

  neuron_param_table #(
    .NumNeurons (NumNeurons),
    .NumInputs  (NumInputs),
    .Width      (Width)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (cfg_we),
    .locked     (busy),
    .addr       (cfg_addr),
    .wdata      (cfg_wdata),
    .sel        (idx_q),
    .rd_weights (tbl_weights),
    .rd_bias    (tbl_bias),
    .wr_err     (cfg_err)
  );

  // State, counters and captured data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      tmo_q     <= '0;
      value_q   <= '0;
      weights_q <= '0;
      bias_q    <= '0;
      results_q <= '0;
      ovf_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      value_q   <= value_d;
      weights_q <= weights_d;
      bias_q    <= bias_d;
      results_q <= results_d;
      ovf_q     <= ovf_d;
      error_q   <= error_d;
    end
  end

  // Next-state and data-capture logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    value_d   = value_q;
    weights_d = weights_q;
    bias_d    = bias_q;
    results_d = results_q;
    ovf_d     = ovf_q;
    error_d   = error_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          value_d = value_in;
          error_d = 1'b0;
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Registered copy keeps the datapath inputs off the table read mux.
        weights_d = tbl_weights;
        bias_d    = tbl_bias;
        state_d   = StWaitRdy;
      end
      StWaitRdy: begin
        if (nrn.ready) begin
          state_d = StFire;
        end
      end
      StFire: begin
        tmo_d   = '0;
        state_d = StWaitRes;
      end
      StWaitRes: begin
        if (nrn.valid_out) begin
          results_d[32'(idx_q)*Width +: Width] = nrn.value_out;
          ovf_d[idx_q] = nrn.overflow;
          state_d      = StNext;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
          if (tmo_d == TmoW'(TimeoutCycles)) begin
            error_d = 1'b1;
            state_d = StFin;
          end
        end
      end
      StNext: begin
        if (idx_q == IdxW'(NumNeurons - 1)) begin
          state_d = StFin;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StLoad;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StFin);
  assign error        = error_q;
  assign results      = results_q;
  assign ovf_flags    = ovf_q;
  assign nrn.weights  = weights_q;
  assign nrn.bias     = bias_q;
  assign nrn.value_in = value_q;
  assign nrn.valid_in = (state_q == StFire);

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer with a behavioural neuron model.
module tb_neuron_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        cfg_err;
  logic        start;
  logic [7:0]  value_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] results;
  logic [3:0]  ovf_flags;

  neuron_layer_sequencer_if #(.NumInputs(2), .Width(8)) nif ();

  neuron_layer_sequencer #(
    .NumNeurons    (4),
    .NumInputs     (2),
    .Width         (8),
    .TimeoutCycles (64)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
    .start     (start),
    .value_in  (value_in),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .results   (results),
    .ovf_flags (ovf_flags),
    .nrn       (nif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Neuron model: answers resp_base+i five cycles after each fire.
  int         skip_idx;
  int         ovf_idx;
  logic [7:0] resp_base;
  int         fires;
  int         mdl_idx;
  int         cur;
  int         dly;
  bit         pend;
  logic [15:0] cap_w [4];
  logic [7:0]  cap_b [4];
  logic [7:0]  cap_v [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fires         <= 0;
      mdl_idx       <= 0;
      cur           <= 0;
      dly           <= 0;
      pend          <= 1'b0;
      nif.valid_out <= 1'b0;
      nif.value_out <= '0;
      nif.overflow  <= 1'b0;
    end else begin
      nif.valid_out <= 1'b0;
      nif.overflow  <= 1'b0;
      if (done) mdl_idx <= 0;
      if (nif.valid_in) begin
        fires <= fires + 1;
        if (mdl_idx < 4) begin
          cap_w[mdl_idx] <= nif.weights;
          cap_b[mdl_idx] <= nif.bias;
          cap_v[mdl_idx] <= nif.value_in;
        end
        cur     <= mdl_idx;
        mdl_idx <= mdl_idx + 1;
        pend    <= 1'b1;
        dly     <= 4;
      end else if (pend) begin
        if (dly == 0) begin
          pend <= 1'b0;
          if (cur != skip_idx) begin
            nif.valid_out <= 1'b1;
            nif.value_out <= resp_base + 8'(cur);
            nif.overflow  <= (cur == ovf_idx);
          end
        end else begin
          dly <= dly - 1;
        end
      end
    end
  end

  int done_cnt = 0;
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] v);
    start    = 1'b1;
    value_in = v;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int c = 0;
    while (done !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (done !== 1'b1) check("done_wait_expired", 32'(done), 32'd1);
  endtask

  task automatic wait_fires(input int target, input int limit);
    int c = 0;
    while (fires < target && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (fires < target) check("fire_wait_expired", 32'(fires), 32'(target));
  endtask

  int f0, d0, seen, t, c;

  initial begin
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    start     = 1'b0;
    value_in  = '0;
    nif.ready = 1'b1;
    skip_idx  = -1;
    ovf_idx   = -1;
    resp_base = 8'h11;
    repeat (3) @(negedge clk);
    check("rst_results", results, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ovf", 32'(ovf_flags), 32'd0);
    check("rst_valid_in", 32'(nif.valid_in), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run: identical parameters, results 0x11..0x14.
    for (int i = 0; i < 4; i++) begin
      cfg_write(4'(i * 3), 8'h20);
      cfg_write(4'(i * 3 + 1), 8'h10);
      cfg_write(4'(i * 3 + 2), 8'h00);
    end
    check("cfg_ok_no_err", 32'(cfg_err), 32'd0);
    f0 = fires;
    d0 = done_cnt;
    pulse_start(8'h20);
    wait_done(200);
    @(negedge clk);
    check("t1_results", results, 32'h14131211);
    check("t1_fires", 32'(fires - f0), 32'd4);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_error", 32'(error), 32'd0);
    check("t1_ovf", 32'(ovf_flags), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_weights", 32'(cap_w[0]), 32'h1020);
    check("t1_value", 32'(cap_v[3]), 32'h20);

    // Ready held low before neuron 1; overflow only on neuron 1.
    resp_base = 8'h21;
    ovf_idx   = 1;
    f0 = fires;
    pulse_start(8'h20);
    wait_fires(f0 + 1, 50);
    nif.ready = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_no_fire_on_hold", 32'(fires - f0), 32'd1);
    check("t2_busy_on_hold", 32'(busy), 32'd1);
    nif.ready = 1'b1;
    wait_done(200);
    @(negedge clk);
    check("t2_results", results, 32'h24232221);
    check("t2_fires", 32'(fires - f0), 32'd4);
    check("t2_ovf", 32'(ovf_flags), 32'b0010);

    // Distinct table, write coinciding with start, busy write, repeat start.
    ovf_idx   = -1;
    resp_base = 8'h31;
    for (int i = 0; i < 4; i++) begin
      cfg_write(4'(i * 3), 8'(8'h30 + i));
      cfg_write(4'(i * 3 + 1), 8'(8'h40 + i));
      if (i != 0) cfg_write(4'(i * 3 + 2), 8'(8'h50 + i));
    end
    f0 = fires;
    d0 = done_cnt;
    cfg_we    = 1'b1;
    cfg_addr  = 4'd2;
    cfg_wdata = 8'h66;
    start     = 1'b1;
    value_in  = 8'h05;
    @(negedge clk);
    cfg_we = 1'b0;
    start  = 1'b0;
    check("t3_same_cycle_no_err", 32'(cfg_err), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    cfg_write(4'd0, 8'hFF);
    check("t3_cfg_err_busy", 32'(cfg_err), 32'd1);
    pulse_start(8'h77);
    check("t3_cfg_err_clear", 32'(cfg_err), 32'd0);
    wait_done(200);
    @(negedge clk);
    check("t3_fires", 32'(fires - f0), 32'd4);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t3_value_kept", 32'(cap_v[3]), 32'h05);
    check("t3_w0", 32'(cap_w[0]), 32'h4030);
    check("t3_b0_same_cycle", 32'(cap_b[0]), 32'h66);
    check("t3_w2", 32'(cap_w[2]), 32'h4232);
    check("t3_b3", 32'(cap_b[3]), 32'h53);
    check("t3_results", results, 32'h34333231);
    cfg_write(4'd12, 8'hAA);
    check("t3_cfg_err_range", 32'(cfg_err), 32'd1);

    // Neuron 2 never answers: abort after the timeout window.
    skip_idx  = 2;
    resp_base = 8'h51;
    pulse_start(8'h09);
    seen = 0;
    t    = 0;
    c    = 0;
    while (done !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
      if (seen == 3) t++;
      if (nif.valid_in === 1'b1) seen++;
    end
    check("t4_done", 32'(done), 32'd1);
    check("t4_fire_to_done", 32'(t), 32'd65);
    check("t4_error", 32'(error), 32'd1);
    check("t4_results", results, 32'h34335251);
    check("t4_busy_write_dropped", 32'(cap_w[0]), 32'h4030);
    @(negedge clk);
    check("t4_error_sticky", 32'(error), 32'd1);
    check("t4_idle", 32'(busy), 32'd0);
    skip_idx = -1;
    pulse_start(8'h09);
    check("t4_start_clears_error", 32'(error), 32'd0);
    wait_done(200);
    @(negedge clk);
    check("t4_rerun_results", results, 32'h54535251);
    check("t4_rerun_error", 32'(error), 32'd0);

    // Asynchronous reset while waiting on neuron 1's result.
    resp_base = 8'h61;
    f0 = fires;
    pulse_start(8'h03);
    wait_fires(f0 + 2, 100);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_results", results, 32'h0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_error", 32'(error), 32'd0);
    check("t5_rst_weights", 32'(nif.weights), 32'h0);
    check("t5_rst_value_in", 32'(nif.value_in), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(8'h01);
    wait_done(200);
    @(negedge clk);
    check("t5_after_rst_results", results, 32'h64636261);
    check("t5_table_cleared", 32'(cap_w[1]), 32'h0);
    check("t5_value", 32'(cap_v[0]), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
- Time-multiplexes one shared NEURON datapath (NUM_INPUTS weights, one bias, WIDTH-bit fixed point) across NUM_NEURONS logical neurons of one layer.
- Holds a per-neuron weight/bias table written over a config port and latches one layer input at START.
- For each neuron in turn it presents that neuron's parameters, fires the datapath, waits for the result and stores it.
- Sits between the register pool (config, START, status) and the NEURON instance, replacing the direct ctrl-bit/edge-detector start path.

Parameters:
- NUM_NEURONS, 4, logical neurons sequenced per layer run (2..16).
- NUM_INPUTS, 2, weights per neuron; must match the NEURON instance.
- WIDTH, 8, data width of weights, bias, values and results.
- TIMEOUT_CYCLES, 64, max cycles from fire to N_VALID_OUT before abort.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  asynchronous active-low reset.
- CFG_WE  in  1  table write strobe.
- CFG_ADDR  in  $clog2(NUM_NEURONS*(NUM_INPUTS+1))  entry index = neuron*(NUM_INPUTS+1)+k; k<NUM_INPUTS selects a weight, k=NUM_INPUTS selects the bias.
- CFG_WDATA  in  WIDTH  entry data.
- CFG_ERR  out  1  one-cycle pulse when a write is dropped.
- START  in  1  one-cycle run request.
- VALUE_IN  in  WIDTH  layer input, sampled on accepted START.
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle pulse at run end (normal or abort).
- ERROR  out  1  sticky timeout flag.
- RESULTS  out  NUM_NEURONS*WIDTH  stored outputs; neuron i is at [i*WIDTH+:WIDTH].
- OVF_FLAGS  out  NUM_NEURONS  per-neuron N_OVERFLOW captured with its result.
- N_WEIGHTS  out  NUM_INPUTS*WIDTH  to NEURON WEIGHTS.
- N_BIAS  out  WIDTH  to NEURON BIAS.
- N_VALUE_IN  out  WIDTH  to NEURON VALUE_IN.
- N_VALID_IN  out  1  to NEURON VALID_IN.
- N_READY  in  1  from NEURON READY.
- N_VALUE_OUT  in  WIDTH  from NEURON VALUE_OUT.
- N_VALID_OUT  in  1  from NEURON VALID_OUT.
- N_OVERFLOW  in  1  from NEURON OVERFLOW.

Behaviour:
- Reset values:
  - All outputs 0; table cleared to 0; state IDLE; neuron index 0.
- States:
  - IDLE: START=1 latches VALUE_IN, clears ERROR, sets index=0 and goes to LOAD.
  - LOAD: drives N_WEIGHTS and N_BIAS from the table entries for the current index; next cycle goes to WAIT_RDY.
  - WAIT_RDY: when N_READY=1, goes to FIRE.
  - FIRE: N_VALID_IN=1 for exactly this cycle; clears the timeout counter; goes to WAIT_RES.
  - WAIT_RES: on N_VALID_OUT=1, captures N_VALUE_OUT into RESULTS[index] and N_OVERFLOW into OVF_FLAGS[index], then goes to NEXT.
    - The counter increments every cycle; reaching TIMEOUT_CYCLES sets ERROR and goes to FIN. RESULTS for this and later neurons keep their old values.
  - NEXT: if index==NUM_NEURONS-1 go to FIN; else index+1 and go to LOAD.
  - FIN: DONE=1 for one cycle; return to IDLE.
- BUSY=1 in every state except IDLE.
- N_WEIGHTS, N_BIAS and N_VALUE_IN stay stable from LOAD through WAIT_RES. They are registered, so they are never combinational from the table.
- Latency:
  - Per neuron: 3 cycles plus waits on READY and on the datapath.
  - DONE asserts 2 cycles after the last N_VALID_OUT.
- START while BUSY is ignored.
- Config writes:
  - A write in IDLE updates the table the next cycle.
  - A write while BUSY, or with CFG_ADDR out of range, is dropped and pulses CFG_ERR. The table stays consistent for the whole run.
- START and CFG_WE in the same IDLE cycle: the write lands, and the run uses the post-write table. LOAD reads the table one cycle later.
- N_VALID_OUT outside WAIT_RES is ignored.
- Asynchronous reset mid-run returns to the reset state immediately. The NEURON shares the same reset domain.
- RESULTS hold their values across runs until overwritten or reset.

Decomposition:
- Shared package:
  - state enum (IDLE, LOAD, WAIT_RDY, FIRE, WAIT_RES, NEXT, FIN);
  - entry-index helper constant ENTRIES = NUM_NEURONS*(NUM_INPUTS+1).
- One natural sub-module: neuron_param_table, a register-file table with a write port, range check and a per-neuron parallel read of NUM_INPUTS weights plus the bias.
- The FSM, index counter, timeout counter and result capture stay in the top.

Test Plan:
- Program 4 neurons (weights 0x20, 0x10, bias 0x00 for all), START with VALUE_IN=0x20, model neuron returns 0x11+i after 5 cycles:
  - RESULTS = {0x14, 0x13, 0x12, 0x11};
  - exactly 4 N_VALID_IN pulses;
  - DONE once; ERROR=0.
- Hold N_READY=0 for 10 cycles before the 2nd neuron: no N_VALID_IN pulse during the hold; run completes once READY rises.
- Model never asserts N_VALID_OUT for neuron 2:
  - ERROR=1 and DONE after TIMEOUT_CYCLES=64;
  - RESULTS[2] and RESULTS[3] unchanged;
  - next START clears ERROR.
- CFG_WE during BUSY, and CFG_ADDR=12 (out of range for 4x3 entries): CFG_ERR pulses, table readback unchanged; a second START while BUSY has no effect.
- Assert N_OVERFLOW with neuron 1's result only: OVF_FLAGS=4'b0010.
- Assert RSTN low during WAIT_RES: all outputs 0 immediately, state IDLE; a fresh run after reset completes normally.
